// File: rtl/condicionador_botoes.sv
// condicionador_botoes: synchronizes and debounces raw push-button lines,
// validates single-button presses and emits one clean pulse per press.
// Optional rejection counter on db_rejeitos: define CONDICIONADOR_REJEITOS_EN.
module condicionador_botoes #(
    parameter int N_BOTOES        = 4,
    parameter int DEBOUNCE_CICLOS = 50000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes,
    input  logic                limpa,
    output logic                jogada_feita,
    output logic [N_BOTOES-1:0] jogada,
    output logic                multipla,
    output logic [1:0]          db_estado,
    output logic [3:0]          db_rejeitos
);

    localparam int LARG_CONT = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [LARG_CONT-1:0] CONT_FINAL = LARG_CONT'(DEBOUNCE_CICLOS - 1);
    localparam logic [LARG_CONT-1:0] CONT_UM    = LARG_CONT'(1);
    localparam logic [N_BOTOES-1:0]  BOTAO_UM   = N_BOTOES'(1);

    typedef enum logic [1:0] {
        OCIOSO        = 2'd0,
        DEBOUNCE      = 2'd1,
        ESPERA_SOLTAR = 2'd2
    } estado_t;

    estado_t               estado;
    estado_t               estado_prox;
    logic [N_BOTOES-1:0]   sinc1;
    logic [N_BOTOES-1:0]   sinc;
    logic [N_BOTOES-1:0]   amostra;
    logic [N_BOTOES-1:0]   amostra_prox;
    logic [LARG_CONT-1:0]  contador;
    logic [LARG_CONT-1:0]  contador_prox;
    logic                  aceita;
    logic                  rejeita_multi;
    logic                  amostra_unica;

    // Exactly one bit set in the captured sample
    assign amostra_unica = (amostra != '0) && ((amostra & (amostra - BOTAO_UM)) == '0);

    assign db_estado = estado;

    // Two-flop synchronizer for the asynchronous button lines
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinc1 <= '0;
            sinc  <= '0;
        end else begin
            sinc1 <= botoes;
            sinc  <= sinc1;
        end
    end

    // FSM state, debounce counter and captured sample
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado   <= OCIOSO;
            contador <= '0;
            amostra  <= '0;
        end else begin
            estado   <= estado_prox;
            contador <= contador_prox;
            amostra  <= amostra_prox;
        end
    end

    // Next-state logic: capture, debounce, accept/reject, wait for release
    always_comb begin
        estado_prox   = estado;
        contador_prox = contador;
        amostra_prox  = amostra;
        aceita        = 1'b0;
        rejeita_multi = 1'b0;
        case (estado)
            OCIOSO: begin
                if (sinc != '0) begin
                    amostra_prox  = sinc;
                    contador_prox = '0;
                    estado_prox   = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (sinc != amostra) begin
                    contador_prox = '0;
                    estado_prox   = OCIOSO;
                end else if (contador < CONT_FINAL) begin
                    contador_prox = contador + CONT_UM;
                end else begin
                    contador_prox = '0;
                    estado_prox   = ESPERA_SOLTAR;
                    if (amostra_unica) begin
                        aceita = 1'b1;
                    end else begin
                        rejeita_multi = 1'b1;
                    end
                end
            end
            ESPERA_SOLTAR: begin
                if (sinc != '0) begin
                    contador_prox = '0;
                end else if (contador < CONT_FINAL) begin
                    contador_prox = contador + CONT_UM;
                end else begin
                    contador_prox = '0;
                    estado_prox   = OCIOSO;
                end
            end
            default: begin
                contador_prox = '0;
                estado_prox   = OCIOSO;
            end
        endcase
    end

    // Registered output pulses and jogada register; acceptance beats limpa
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            jogada_feita <= 1'b0;
            multipla     <= 1'b0;
            jogada       <= '0;
        end else begin
            jogada_feita <= aceita;
            multipla     <= rejeita_multi;
            if (aceita) begin
                jogada <= amostra;
            end else if (limpa) begin
                jogada <= '0;
            end
        end
    end

`ifdef CONDICIONADOR_REJEITOS_EN
    logic [3:0] rejeitos;
    logic       aborto;

    assign aborto      = (estado == DEBOUNCE) && (sinc != amostra);
    assign db_rejeitos = rejeitos;

    // Saturating count of debounce aborts and multi-button rejections
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rejeitos <= '0;
        end else if ((aborto || rejeita_multi) && (rejeitos != 4'hF)) begin
            rejeitos <= rejeitos + 4'd1;
        end
    end
`else
    assign db_rejeitos = 4'h0;
`endif

endmodule

// File: doc/condicionador_botoes.md
Name: condicionador_botoes

Overview:
Input-conditioning stage directly upstream of the game datapath's button register and edge detector. Takes raw, asynchronous, bouncing push-button lines and synchronizes and debounces them. Validates that exactly one button is pressed, then delivers a clean one-cycle `jogada_feita` pulse plus a registered one-hot `jogada` value for the control unit and datapath. Each physical press yields exactly one pulse, regardless of hold time.

Parameters:
- N_BOTOES, 4: number of button lines.
- DEBOUNCE_CICLOS, 50000: stable cycles required for press and release acceptance (1 ms at 50 MHz); legal range ≥ 2.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- botoes  in  N_BOTOES  raw button lines, active-high, asynchronous to clock
- limpa  in  1  synchronous clear of the `jogada` register (driven by the control unit alongside edge-detector reset)
- jogada_feita  out  1  one-cycle pulse: valid single-button press accepted
- jogada  out  N_BOTOES  registered one-hot value of the last accepted press
- multipla  out  1  one-cycle pulse: stable press with more than one button rejected
- db_estado  out  2  FSM state for debug display
- db_rejeitos  out  4  count of rejected presses (see Optional Feature)

Behaviour:
- Clock and reset: single clock domain; reset is asynchronous and active-high.
- Reset values: all outputs are 0; both synchronizer stages are 0; internal sample `amostra` is 0; counter is 0; state is OCIOSO.
- Synchronizer: 2-flop synchronizer per bit; the FSM sees only the stage-2 value `sinc`.
- Counter: width $clog2(DEBOUNCE_CICLOS+1); cleared on every state entry and on every abort.
- State encoding (`db_estado`): OCIOSO = 0, DEBOUNCE = 1, ESPERA_SOLTAR = 2. Code 3 is illegal and recovers to OCIOSO on the next edge.
- OCIOSO:
  - `sinc` ≠ 0 → load `amostra` ← `sinc`, go to DEBOUNCE.
  - Otherwise stay.
- DEBOUNCE:
  - `sinc` ≠ `amostra` → abort: go to OCIOSO, count one rejection.
  - `sinc` = `amostra` and counter < DEBOUNCE_CICLOS−1 → increment counter.
  - `sinc` = `amostra` and counter = DEBOUNCE_CICLOS−1, with `amostra` one-hot → `jogada` ← `amostra`, pulse `jogada_feita`, go to ESPERA_SOLTAR.
  - Same terminal condition with `amostra` not one-hot → pulse `multipla`, count one rejection, `jogada` unchanged, go to ESPERA_SOLTAR.
- ESPERA_SOLTAR:
  - `sinc` ≠ 0 → clear counter, stay.
  - `sinc` = 0 for DEBOUNCE_CICLOS consecutive cycles → go to OCIOSO.
  - Any new button activity while waiting never produces a pulse.
- Latency: let edge k be the first edge that samples the new raw value into stage 1. `jogada_feita` or `multipla` is high during the cycle after edge k+DEBOUNCE_CICLOS+2, for exactly one cycle. The pulses are registered outputs.
- `limpa`:
  - Clears `jogada` to 0 on the next edge.
  - Has no effect on FSM state or counter.
  - If `limpa` coincides with an acceptance edge, the acceptance wins: `jogada` loads `amostra` and the pulse is issued.
- Reset mid-operation: the operation is aborted immediately and no pulse is emitted. A button still held after reset deasserts is treated as a new press and goes through the full debounce.
- `jogada_feita` and `multipla` are never high in the same cycle.

Optional Feature:
- Macro: CONDICIONADOR_REJEITOS_EN
- Defined:
  - `db_rejeitos` is a 4-bit counter incremented once per DEBOUNCE abort and once per `multipla` event.
  - Saturates at 4'hF.
  - Cleared only by `reset`.
- Undefined: `db_rejeitos` is tied to 4'h0 and no counter logic is synthesized.

Test Plan (N_BOTOES = 4, DEBOUNCE_CICLOS = 4, macro defined):
1. `botoes` = 0100 held 20 cycles from edge k → `jogada_feita` high only in the cycle after edge k+6; `jogada` = 0100; `db_estado` = 2 until 4 cycles after release is synchronized, then 0.
2. `botoes` = 0010 for 2 cycles, 0000 for 1 cycle, then 0010 held 15 cycles → exactly one `jogada_feita` pulse; `jogada` = 0010; `db_rejeitos` = 1.
3. `botoes` = 0011 held 15 cycles → one `multipla` pulse; no `jogada_feita`; `jogada` keeps its prior value; `db_rejeitos` increments by 1.
4. `botoes` = 1000 held 50 cycles, released 10 cycles, pressed again → exactly two `jogada_feita` pulses in total; `jogada` = 1000.
5. `limpa` pulsed after acceptance → `jogada` = 0000 on the next edge. `limpa` asserted on the acceptance edge → `jogada` = pressed value and pulse present.
6. `reset` asserted while `db_estado` = 1 → all outputs 0 immediately, no pulse. With the button still held after release of `reset` → pulse occurs after the full latency.
